mac_accum_feeder: RTL and testbench

MAC_ACCUM_FEEDER -- requirements
Module: mac_accum_feeder

---
 rtl/mac_accum_feeder_if.sv | 44 ++++
 rtl/mac_accum_feeder.sv | 175 +++++++++++++++++
 tb/tb_mac_accum_feeder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accum_feeder_if.sv
// Handshake and data bundle between the operand source / job controller and
// the MAC accumulator feeder. The slave side is the feeder itself.
interface mac_accum_feeder_if #(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BIAS_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int CH_WIDTH   = 4
) ();
    // Job control
    logic                  start;
    logic [CNT_WIDTH-1:0]  len;
    logic [CH_WIDTH-1:0]   num_ch;
    logic                  busy;
    logic                  done;

    // Operand stream
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   act_data;
    logic [IN_WIDTH-1:0]   wgt_data;

    // Bias table write port
    logic                  bias_wr_en;
    logic [CH_WIDTH-1:0]   bias_wr_addr;
    logic [BIAS_WIDTH-1:0] bias_wr_data;

    // Result towards the bias-add stage
    logic [DATA_WIDTH-1:0] mac_data;
    logic [BIAS_WIDTH-1:0] bias_data;
    logic                  valid_out;

    modport master (
        output start, len, num_ch, in_valid, act_data, wgt_data,
               bias_wr_en, bias_wr_addr, bias_wr_data,
        input  in_ready, mac_data, bias_data, valid_out, busy, done
    );

    modport slave (
        input  start, len, num_ch, in_valid, act_data, wgt_data,
               bias_wr_en, bias_wr_addr, bias_wr_data,
        output in_ready, mac_data, bias_data, valid_out, busy, done
    );
endinterface

// File: rtl/mac_accum_feeder.sv
// MAC accumulator feeder: accumulates len signed act*wgt products per output
// channel, then emits the saturated sum together with that channel's bias for
// one cycle. Repeats for num_ch channels and pulses done at the end.
module mac_accum_feeder #(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8,
    parameter int CH_WIDTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    mac_accum_feeder_if.slave   bus
);

    localparam int PROD_WIDTH = 2 * IN_WIDTH;
    localparam int NUM_BIAS   = 1 << CH_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CH_WIDTH-1:0]  CH_ONE  = 1;

    // Signed saturation bounds of DATA_WIDTH, expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                   state_q,     state_d;
    logic [CNT_WIDTH-1:0]         len_q,       len_d;
    logic [CNT_WIDTH-1:0]         cnt_q,       cnt_d;
    logic [CH_WIDTH-1:0]          num_ch_q,    num_ch_d;
    logic [CH_WIDTH-1:0]          ch_q,        ch_d;
    logic signed [ACC_WIDTH-1:0]  acc_q,       acc_d;
    logic [DATA_WIDTH-1:0]        mac_data_q,  mac_data_d;
    logic [BIAS_WIDTH-1:0]        bias_data_q, bias_data_d;
    logic                         done_q,      done_d;

    logic [BIAS_WIDTH-1:0]        bias_table [NUM_BIAS];

    logic                         start_ok;
    logic signed [PROD_WIDTH-1:0] act_ext;
    logic signed [PROD_WIDTH-1:0] wgt_ext;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic [CNT_WIDTH-1:0]         cnt_inc;
    logic                         last_ch;

    // Clamp the accumulator into the signed DATA_WIDTH range.
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    // A zero-length or zero-channel job is meaningless and is dropped.
    assign start_ok = bus.start && (bus.len != '0) && (bus.num_ch != '0);

    // Full-precision signed product, sign-extended into the accumulator width.
    assign act_ext  = {{IN_WIDTH{bus.act_data[IN_WIDTH-1]}}, bus.act_data};
    assign wgt_ext  = {{IN_WIDTH{bus.wgt_data[IN_WIDTH-1]}}, bus.wgt_data};
    assign prod     = act_ext * wgt_ext;
    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign acc_sum  = acc_q + prod_ext;
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign last_ch  = (ch_q == (num_ch_q - CH_ONE));

    // Next-state logic for the job FSM, accumulator, counters and output regs.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        num_ch_d    = num_ch_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        mac_data_d  = mac_data_q;
        bias_data_d = bias_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d    = bus.len;
                    num_ch_d = bus.num_ch;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ch_d     = '0;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        // Load the result registers on the last-term edge so
                        // they are valid during the single EMIT cycle.
                        mac_data_d  = saturate(acc_sum);
                        bias_data_d = bias_table[ch_q];
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                acc_d = '0;
                cnt_d = '0;
                if (last_ch) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + CH_ONE;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            num_ch_q    <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            mac_data_q  <= '0;
            bias_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            num_ch_q    <= num_ch_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            mac_data_q  <= mac_data_d;
            bias_data_q <= bias_data_d;
            done_q      <= done_d;
        end
    end

    // Bias table writes, accepted only while no job is running.
    always_ff @(posedge clk) begin
        // NOTE: the table is deliberately not reset; clearing a RAM-style
        // array would cost a reset fan-out to every entry and block RAM mapping.
        if (!rst && bus.bias_wr_en && (state_q == ST_IDLE)) begin
            bias_table[bus.bias_wr_addr] <= bus.bias_wr_data;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.valid_out = (state_q == ST_EMIT);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.mac_data  = mac_data_q;
    assign bus.bias_data = bias_data_q;

endmodule

// File: tb/tb_mac_accum_feeder.sv
// Directed bench for mac_accum_feeder with a queue-based scoreboard: the
// stimulus side pushes the expected (mac_data, bias_data) per channel and an
// independent monitor compares every valid_out beat against the queue head.
module tb_mac_accum_feeder;

    typedef struct {
        logic [15:0] mac;
        logic [15:0] bias;
    } exp_t;

    logic clk;
    logic rst;

    mac_accum_feeder_if bus ();

    mac_accum_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   valid_cnt = 0;
    int   done_cnt  = 0;
    int   exp_valid = 0;
    int   exp_done  = 0;
    logic prev_valid = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic push_exp(input logic [15:0] mac, input logic [15:0] bias);
        exp_t e;
        e.mac  = mac;
        e.bias = bias;
        exp_q.push_back(e);
        exp_valid++;
    endtask

    // Monitor: compares each emitted channel and checks done sequencing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_valid: mac_data 0x%0h with empty scoreboard at %0t",
                             bus.mac_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mac_data", 32'(bus.mac_data), 32'(e.mac));
                    check("bias_data", 32'(bus.bias_data), 32'(e.bias));
                    check("in_ready_in_emit", 32'(bus.in_ready), 32'd0);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                check("done_follows_emit", 32'(prev_valid), 32'd1);
                check("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
            prev_valid = bus.valid_out;
        end
    end

    // Absolute watchdog so the run can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic bias_write(input logic [3:0] addr, input logic [15:0] data);
        bus.bias_wr_en   = 1'b1;
        bus.bias_wr_addr = addr;
        bus.bias_wr_data = data;
        @(posedge clk);
        #1 bus.bias_wr_en = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] len, input logic [3:0] nch);
        bus.start  = 1'b1;
        bus.len    = len;
        bus.num_ch = nch;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Present one operand pair and hold it until the DUT accepts it.
    task automatic send_pair(input int a, input int w);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.act_data = 8'(a);
        bus.wgt_data = 8'(w);
        while (1) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                timeout_fail("in_ready_wait");
                break;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for the job to finish and the scoreboard to drain.
    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.busy === 1'b0 && exp_q.size() == 0) break;
            n++;
            if (n > 200) begin
                timeout_fail("job_completion");
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.len          = '0;
        bus.num_ch       = '0;
        bus.in_valid     = 1'b0;
        bus.act_data     = '0;
        bus.wgt_data     = '0;
        bus.bias_wr_en   = 1'b0;
        bus.bias_wr_addr = '0;
        bus.bias_wr_data = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_mac_data", 32'(bus.mac_data), 32'd0);
        check("rst_bias_data", 32'(bus.bias_data), 32'd0);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        idle_cycle();

        // Basic: 2*3 - 4*5 + 7*1 = -7
        bias_write(4'd0, 16'd5);
        push_exp(16'hFFF9, 16'd5);
        exp_done++;
        start_job(8'd3, 4'd1);
        send_pair(2, 3);
        send_pair(-4, 5);
        send_pair(7, 1);
        wait_idle();
        check("basic_done_count", 32'(done_cnt), 32'(exp_done));
        check("basic_busy_after", 32'(bus.busy), 32'd0);
        check("basic_mac_hold", 32'(bus.mac_data), 32'h0000FFF9);
        check("basic_bias_hold", 32'(bus.bias_data), 32'd5);

        // Saturation high: 4 * 16129 = 64516
        push_exp(16'h7FFF, 16'd5);
        exp_done++;
        start_job(8'd4, 4'd1);
        for (int i = 0; i < 4; i++) send_pair(127, 127);
        wait_idle();

        // Saturation low: 4 * -16256 = -65024
        push_exp(16'h8000, 16'd5);
        exp_done++;
        start_job(8'd4, 4'd1);
        for (int i = 0; i < 4; i++) send_pair(-128, 127);
        wait_idle();
        check("sat_done_count", 32'(done_cnt), 32'(exp_done));

        // Multi-channel with stalls between operand pairs
        bias_write(4'd0, 16'd10);
        bias_write(4'd1, 16'd20);
        bias_write(4'd2, 16'd30);
        push_exp(16'd14, 16'd10);      // 1*2 + 3*4
        push_exp(16'hFFAA, 16'd20);    // -5*6 + 7*-8 = -86
        push_exp(16'h270F, 16'd30);    // 100*100 - 1 = 9999
        exp_done++;
        start_job(8'd2, 4'd3);
        send_pair(1, 2);   idle_cycle();
        send_pair(3, 4);   idle_cycle();
        send_pair(-5, 6);  idle_cycle();
        send_pair(7, -8);  idle_cycle();
        send_pair(100, 100); idle_cycle();
        send_pair(-1, 1);
        wait_idle();
        check("multi_valid_count", 32'(valid_cnt), 32'(exp_valid));
        check("multi_done_count", 32'(done_cnt), 32'(exp_done));

        // Ignored starts with a zero length or zero channel count
        start_job(8'd0, 4'd2);
        @(negedge clk);
        check("len0_busy", 32'(bus.busy), 32'd0);
        idle_cycle();
        start_job(8'd3, 4'd0);
        @(negedge clk);
        check("nch0_busy", 32'(bus.busy), 32'd0);
        idle_cycle();

        // Start and bias write during a job are both ignored
        push_exp(16'd8, 16'd10);       // 2*2 + 2*2
        push_exp(16'd2, 16'd20);       // 1 + 1, bias entry 1 unchanged
        exp_done++;
        start_job(8'd2, 4'd2);
        send_pair(2, 2);
        bus.start        = 1'b1;
        bus.len          = 8'd5;
        bus.num_ch       = 4'd1;
        bus.bias_wr_en   = 1'b1;
        bus.bias_wr_addr = 4'd1;
        bus.bias_wr_data = 16'd99;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.bias_wr_en = 1'b0;
        send_pair(2, 2);
        send_pair(1, 1);
        send_pair(1, 1);
        wait_idle();
        check("ignored_valid_count", 32'(valid_cnt), 32'(exp_valid));
        check("ignored_done_count", 32'(done_cnt), 32'(exp_done));

        // Next job: bias[1] keeps its old value; bias[0] written with start
        push_exp(16'd9, 16'd77);       // 3*3, coincident write visible
        push_exp(16'hFFF7, 16'd20);    // -3*3 = -9
        exp_done++;
        bus.bias_wr_en   = 1'b1;
        bus.bias_wr_addr = 4'd0;
        bus.bias_wr_data = 16'd77;
        start_job(8'd1, 4'd2);
        bus.bias_wr_en = 1'b0;
        send_pair(3, 3);
        send_pair(-3, 3);
        wait_idle();

        // Reset mid-job: aborts with no valid_out or done
        start_job(8'd3, 4'd1);
        send_pair(50, 50);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_valid_count", 32'(valid_cnt), 32'(exp_valid));
        check("midrst_done_count", 32'(done_cnt), 32'(exp_done));

        // Fresh job after reset starts from a zero accumulator
        push_exp(16'hFFFA, 16'd77);    // 3*-2 = -6
        exp_done++;
        start_job(8'd1, 4'd1);
        send_pair(3, -2);
        wait_idle();
        check("final_valid_count", 32'(valid_cnt), 32'(exp_valid));
        check("final_done_count", 32'(done_cnt), 32'(exp_done));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
